// File: rtl/turf_udp_port_switch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : turf_udp_port_switch_pkg
// Description : Shared definitions for the TURF UDP port switch. This package
//               holds the RX and TX state encodings and the bit offsets of the
//               64-bit UDP header word {ip[63:32], port[31:16], length[15:0]}.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package turf_udp_port_switch_pkg;

  // 64-bit header word layout
  localparam int HDR_WIDTH    = 64;
  localparam int HDR_IP_OFS   = 32;
  localparam int HDR_IP_W     = 32;
  localparam int HDR_PORT_OFS = 16;
  localparam int HDR_PORT_W   = 16;
  localparam int HDR_LEN_OFS  = 0;
  localparam int HDR_LEN_W    = 16;

  // Receive-side demultiplexer states
  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_HDR  = 2'd1,
    RX_DATA = 2'd2,
    RX_DROP = 2'd3
  } rx_state_t;

  // Transmit-side multiplexer states
  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_HDR  = 2'd1,
    TX_DATA = 2'd2
  } tx_state_t;

endpackage : turf_udp_port_switch_pkg
`default_nettype wire

// File: rtl/turf_udp_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : turf_udp_rr_arb
// Description : Combinational round-robin arbiter. It picks the first asserted
//               request at or above rr_ptr, searching upward and wrapping
//               modulo NUM_PORTS.
// Ports       : req          in  NUM_PORTS  request vector
//               rr_ptr       in  IDX_W      search start position
//               grant_onehot out NUM_PORTS  one-hot grant (all zero if no req)
//               grant_idx    out IDX_W      binary index of the grant
// Revision    : 1.0 - initial release
// ============================================================================
module turf_udp_rr_arb
  import turf_udp_port_switch_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     rr_ptr,
  output logic [NUM_PORTS-1:0] grant_onehot,
  output logic [IDX_W-1:0]     grant_idx
);

  logic found;
  int   cand;

  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    found        = 1'b0;
    cand         = 0;
    for (int off = 0; off < NUM_PORTS; off++) begin
      // rr_ptr is always kept below NUM_PORTS, so one subtraction is enough
      cand = int'(rr_ptr) + off;
      if (cand >= NUM_PORTS) begin
        cand = cand - NUM_PORTS;
      end
      if (!found && req[cand]) begin
        found              = 1'b1;
        grant_onehot[cand] = 1'b1;
        grant_idx          = IDX_W'(cand);
      end
    end
  end

endmodule : turf_udp_rr_arb
`default_nettype wire

// File: rtl/turf_udp_port_switch.sv
`default_nettype none
// ============================================================================
// Module      : turf_udp_port_switch
// Description : Switches UDP traffic between one network-side UDP stack and
//               NUM_PORTS application channels.
//               RX: a received header is routed by destination port to
//               channel (dst_port - PORT_BASE). If no channel matches, the
//               payload is discarded and drop_count is incremented.
//               TX: the channel headers/payloads are merged round-robin onto a
//               single transmit stream, and m_txhdr_tuser carries the source
//               port.
// Ports       : clk, rst_n                  clock, async active-low reset
//               s_udphdr_* / s_udpdata_*    received header / payload in
//               m_udphdr_* / m_udpdata_*    per-channel received streams out
//               s_txhdr_*  / s_txdata_*     per-channel transmit streams in
//               m_txhdr_*  / m_txdata_*     merged transmit stream out
//               drop_count                  unmatched-port packet counter
// Revision    : 1.0 - initial release
// ============================================================================
module turf_udp_port_switch
  import turf_udp_port_switch_pkg::*;
#(
  parameter int          NUM_PORTS  = 4,
  parameter logic [15:0] PORT_BASE  = 16'd21600,
  parameter int          DATA_WIDTH = 64,
  parameter int          CNT_WIDTH  = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  // received header / payload from the UDP stack
  input  logic                              s_udphdr_tvalid,
  output logic                              s_udphdr_tready,
  input  logic [63:0]                       s_udphdr_tdata,
  input  logic [15:0]                       s_udphdr_tdest,
  input  logic                              s_udpdata_tvalid,
  output logic                              s_udpdata_tready,
  input  logic                              s_udpdata_tlast,
  input  logic [DATA_WIDTH-1:0]             s_udpdata_tdata,
  input  logic [DATA_WIDTH/8-1:0]           s_udpdata_tkeep,
  // per-channel received streams
  output logic [NUM_PORTS-1:0]              m_udphdr_tvalid,
  input  logic [NUM_PORTS-1:0]              m_udphdr_tready,
  output logic [NUM_PORTS*64-1:0]           m_udphdr_tdata,
  output logic [NUM_PORTS-1:0]              m_udpdata_tvalid,
  input  logic [NUM_PORTS-1:0]              m_udpdata_tready,
  output logic [NUM_PORTS-1:0]              m_udpdata_tlast,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]   m_udpdata_tdata,
  output logic [NUM_PORTS*DATA_WIDTH/8-1:0] m_udpdata_tkeep,
  // per-channel transmit streams
  input  logic [NUM_PORTS-1:0]              s_txhdr_tvalid,
  output logic [NUM_PORTS-1:0]              s_txhdr_tready,
  input  logic [NUM_PORTS*64-1:0]           s_txhdr_tdata,
  input  logic [NUM_PORTS-1:0]              s_txdata_tvalid,
  output logic [NUM_PORTS-1:0]              s_txdata_tready,
  input  logic [NUM_PORTS-1:0]              s_txdata_tlast,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   s_txdata_tdata,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] s_txdata_tkeep,
  // merged transmit stream to the UDP stack
  output logic                              m_txhdr_tvalid,
  input  logic                              m_txhdr_tready,
  output logic [63:0]                       m_txhdr_tdata,
  output logic [15:0]                       m_txhdr_tuser,
  output logic                              m_txdata_tvalid,
  input  logic                              m_txdata_tready,
  output logic                              m_txdata_tlast,
  output logic [DATA_WIDTH-1:0]             m_txdata_tdata,
  output logic [DATA_WIDTH/8-1:0]           m_txdata_tkeep,
  // statistics
  output logic [CNT_WIDTH-1:0]              drop_count
);

  localparam int IDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int KEEP_W = DATA_WIDTH / 8;

  // ==========================================================================
  // RX path
  // ==========================================================================
  rx_state_t                rx_state, rx_state_nxt;
  logic [HDR_WIDTH-1:0]     rx_hdr;
  logic [IDX_W-1:0]         rx_ch;
  logic [CNT_WIDTH-1:0]     drop_cnt;
  logic                     rx_arm;
  logic [15:0]              hdr_idx;
  logic                     hdr_take;
  logic                     hdr_match;

  // A destination below PORT_BASE wraps to a large index and fails the match.
  assign hdr_idx   = s_udphdr_tdest - PORT_BASE;
  assign hdr_match = (hdr_idx < 16'(NUM_PORTS));
  assign hdr_take  = (rx_state == RX_IDLE) && rx_arm && s_udphdr_tvalid;

  always_comb begin
    rx_state_nxt     = rx_state;
    s_udphdr_tready  = 1'b0;
    s_udpdata_tready = 1'b0;
    m_udphdr_tvalid  = '0;
    m_udpdata_tvalid = '0;
    m_udpdata_tlast  = '0;
    case (rx_state)
      RX_IDLE: begin
        // rx_arm keeps header tready low while reset is asserted
        s_udphdr_tready = rx_arm;
        if (hdr_take) begin
          rx_state_nxt = hdr_match ? RX_HDR : RX_DROP;
        end
      end
      RX_HDR: begin
        m_udphdr_tvalid[rx_ch] = 1'b1;
        if (m_udphdr_tready[rx_ch]) begin
          rx_state_nxt = RX_DATA;
        end
      end
      RX_DATA: begin
        s_udpdata_tready        = m_udpdata_tready[rx_ch];
        m_udpdata_tvalid[rx_ch] = s_udpdata_tvalid;
        m_udpdata_tlast[rx_ch]  = s_udpdata_tlast;
        if (s_udpdata_tvalid && m_udpdata_tready[rx_ch] && s_udpdata_tlast) begin
          rx_state_nxt = RX_IDLE;
        end
      end
      RX_DROP: begin
        s_udpdata_tready = 1'b1;
        if (s_udpdata_tvalid && s_udpdata_tlast) begin
          rx_state_nxt = RX_IDLE;
        end
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      rx_hdr   <= '0;
      rx_ch    <= '0;
      drop_cnt <= '0;
      rx_arm   <= 1'b0;
    end else begin
      rx_state <= rx_state_nxt;
      rx_arm   <= 1'b1;
      if (hdr_take) begin
        rx_hdr <= s_udphdr_tdata;
        rx_ch  <= hdr_idx[IDX_W-1:0];
      end
      if ((rx_state == RX_DROP) && s_udpdata_tvalid && s_udpdata_tlast &&
          (drop_cnt != {CNT_WIDTH{1'b1}})) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  assign drop_count = drop_cnt;

  // Data and header words fan out to every channel. Only tvalid selects the
  // channel that owns the packet.
  generate
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_rx_fanout
      assign m_udphdr_tdata[HDR_WIDTH*i +: HDR_WIDTH]   = rx_hdr;
      assign m_udpdata_tdata[DATA_WIDTH*i +: DATA_WIDTH] = s_udpdata_tdata;
      assign m_udpdata_tkeep[KEEP_W*i +: KEEP_W]         = s_udpdata_tkeep;
    end
  endgenerate

  // ==========================================================================
  // TX path
  // ==========================================================================
  tx_state_t                tx_state, tx_state_nxt;
  logic [IDX_W-1:0]         grant;
  logic [IDX_W-1:0]         rr_ptr;
  logic [NUM_PORTS-1:0]     arb_onehot;
  logic [IDX_W-1:0]         arb_idx;
  logic                     arb_valid;
  logic                     tx_last_beat;

  turf_udp_rr_arb #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_rr_arb (
    .req          (s_txhdr_tvalid),
    .rr_ptr       (rr_ptr),
    .grant_onehot (arb_onehot),
    .grant_idx    (arb_idx)
  );

  assign arb_valid    = |arb_onehot;
  assign tx_last_beat = (tx_state == TX_DATA) && s_txdata_tvalid[grant] &&
                        m_txdata_tready && s_txdata_tlast[grant];

  // The payload and header words follow the registered grant. The grant only
  // changes in IDLE, so a packet can never switch sources part way through.
  assign m_txhdr_tdata  = s_txhdr_tdata[HDR_WIDTH*int'(grant) +: HDR_WIDTH];
  assign m_txhdr_tuser  = PORT_BASE + 16'(grant);
  assign m_txdata_tdata = s_txdata_tdata[DATA_WIDTH*int'(grant) +: DATA_WIDTH];
  assign m_txdata_tkeep = s_txdata_tkeep[KEEP_W*int'(grant) +: KEEP_W];

  always_comb begin
    tx_state_nxt    = tx_state;
    m_txhdr_tvalid  = 1'b0;
    s_txhdr_tready  = '0;
    m_txdata_tvalid = 1'b0;
    m_txdata_tlast  = 1'b0;
    s_txdata_tready = '0;
    case (tx_state)
      TX_IDLE: begin
        if (arb_valid) begin
          tx_state_nxt = TX_HDR;
        end
      end
      TX_HDR: begin
        m_txhdr_tvalid        = s_txhdr_tvalid[grant];
        s_txhdr_tready[grant] = m_txhdr_tready;
        if (s_txhdr_tvalid[grant] && m_txhdr_tready) begin
          tx_state_nxt = TX_DATA;
        end
      end
      TX_DATA: begin
        m_txdata_tvalid        = s_txdata_tvalid[grant];
        m_txdata_tlast         = s_txdata_tlast[grant];
        s_txdata_tready[grant] = m_txdata_tready;
        if (tx_last_beat) begin
          tx_state_nxt = TX_IDLE;
        end
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
    end else begin
      tx_state <= tx_state_nxt;
      if ((tx_state == TX_IDLE) && arb_valid) begin
        grant <= arb_idx;
      end
      // The search for the next packet starts just after the channel that
      // was served most recently.
      if (tx_last_beat) begin
        if (int'(grant) == NUM_PORTS - 1) begin
          rr_ptr <= '0;
        end else begin
          rr_ptr <= grant + 1'b1;
        end
      end
    end
  end

endmodule : turf_udp_port_switch
`default_nettype wire

// File: tb/tb_turf_udp_port_switch.sv
`default_nettype none
// ============================================================================
// Module      : tb_turf_udp_port_switch
// Description : Directed self-checking bench for turf_udp_port_switch. It
//               covers RX routing, drop and saturation, backpressure, TX
//               round-robin merging and reset in the middle of a packet.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_turf_udp_port_switch;

  localparam int NP = 4;
  localparam int DW = 64;
  localparam int CW = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              s_udphdr_tvalid, s_udphdr_tready;
  logic [63:0]       s_udphdr_tdata;
  logic [15:0]       s_udphdr_tdest;
  logic              s_udpdata_tvalid, s_udpdata_tready, s_udpdata_tlast;
  logic [DW-1:0]     s_udpdata_tdata;
  logic [DW/8-1:0]   s_udpdata_tkeep;
  logic [NP-1:0]     m_udphdr_tvalid, m_udphdr_tready;
  logic [NP*64-1:0]  m_udphdr_tdata;
  logic [NP-1:0]     m_udpdata_tvalid, m_udpdata_tready, m_udpdata_tlast;
  logic [NP*DW-1:0]  m_udpdata_tdata;
  logic [NP*DW/8-1:0] m_udpdata_tkeep;
  logic [NP-1:0]     s_txhdr_tvalid, s_txhdr_tready;
  logic [NP*64-1:0]  s_txhdr_tdata;
  logic [NP-1:0]     s_txdata_tvalid, s_txdata_tready, s_txdata_tlast;
  logic [NP*DW-1:0]  s_txdata_tdata;
  logic [NP*DW/8-1:0] s_txdata_tkeep;
  logic              m_txhdr_tvalid, m_txhdr_tready;
  logic [63:0]       m_txhdr_tdata;
  logic [15:0]       m_txhdr_tuser;
  logic              m_txdata_tvalid, m_txdata_tready, m_txdata_tlast;
  logic [DW-1:0]     m_txdata_tdata;
  logic [DW/8-1:0]   m_txdata_tkeep;
  logic [CW-1:0]     drop_count;

  int total = 0;
  int bad   = 0;
  int exp_ch [4];

  always #5 clk = ~clk;

  turf_udp_port_switch #(
    .NUM_PORTS(NP), .PORT_BASE(16'd21600), .DATA_WIDTH(DW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_udphdr_tvalid(s_udphdr_tvalid), .s_udphdr_tready(s_udphdr_tready),
    .s_udphdr_tdata(s_udphdr_tdata), .s_udphdr_tdest(s_udphdr_tdest),
    .s_udpdata_tvalid(s_udpdata_tvalid), .s_udpdata_tready(s_udpdata_tready),
    .s_udpdata_tlast(s_udpdata_tlast), .s_udpdata_tdata(s_udpdata_tdata),
    .s_udpdata_tkeep(s_udpdata_tkeep),
    .m_udphdr_tvalid(m_udphdr_tvalid), .m_udphdr_tready(m_udphdr_tready),
    .m_udphdr_tdata(m_udphdr_tdata),
    .m_udpdata_tvalid(m_udpdata_tvalid), .m_udpdata_tready(m_udpdata_tready),
    .m_udpdata_tlast(m_udpdata_tlast), .m_udpdata_tdata(m_udpdata_tdata),
    .m_udpdata_tkeep(m_udpdata_tkeep),
    .s_txhdr_tvalid(s_txhdr_tvalid), .s_txhdr_tready(s_txhdr_tready),
    .s_txhdr_tdata(s_txhdr_tdata),
    .s_txdata_tvalid(s_txdata_tvalid), .s_txdata_tready(s_txdata_tready),
    .s_txdata_tlast(s_txdata_tlast), .s_txdata_tdata(s_txdata_tdata),
    .s_txdata_tkeep(s_txdata_tkeep),
    .m_txhdr_tvalid(m_txhdr_tvalid), .m_txhdr_tready(m_txhdr_tready),
    .m_txhdr_tdata(m_txhdr_tdata), .m_txhdr_tuser(m_txhdr_tuser),
    .m_txdata_tvalid(m_txdata_tvalid), .m_txdata_tready(m_txdata_tready),
    .m_txdata_tlast(m_txdata_tlast), .m_txdata_tdata(m_txdata_tdata),
    .m_txdata_tkeep(m_txdata_tkeep),
    .drop_count(drop_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] tx_hdr_word(input int ch);
    return {32'h0A00_0000 | 32'(ch), 16'd5000 + 16'(ch), 16'd16};
  endfunction

  function automatic logic [63:0] tx_word(input int ch, input int b);
    return 64'hD000_0000_0000_0000 | (64'(ch) << 8) | 64'(b);
  endfunction

  // Presents one header in IDLE and completes its handshake
  task automatic rx_hdr(input logic [15:0] dest, input logic [63:0] h);
    s_udphdr_tvalid = 1'b1;
    s_udphdr_tdata  = h;
    s_udphdr_tdest  = dest;
    #1;
    check("rx_hdr_tready", 64'(s_udphdr_tready), 64'd1);
    check("rx_hdr_latency", 64'(m_udphdr_tvalid), 64'd0);
    step();
    s_udphdr_tvalid = 1'b0;
  endtask

  // Sends a packet to an unmatched port. Every beat must be swallowed.
  task automatic rx_drop(input logic [15:0] dest, input int nbeats);
    rx_hdr(dest, 64'hBAD0_0000_0000_0000 | 64'(dest));
    #1;
    check("drop_no_hdr", 64'(m_udphdr_tvalid), 64'd0);
    for (int b = 0; b < nbeats; b++) begin
      s_udpdata_tvalid = 1'b1;
      s_udpdata_tdata  = 64'hEE00 + 64'(b);
      s_udpdata_tlast  = (b == nbeats - 1);
      #1;
      check("drop_tready", 64'(s_udpdata_tready), 64'd1);
      check("drop_no_data", 64'(m_udpdata_tvalid), 64'd0);
      step();
    end
    s_udpdata_tvalid = 1'b0;
    s_udpdata_tlast  = 1'b0;
  endtask

  // Drives the channel sources as independent AXI masters and checks the
  // merged stream against the expected channel order in exp_ch.
  task automatic tx_run(input logic [3:0] chans, input int n);
    logic [3:0] hp, dp, hr, dr;
    int bt [4];
    int hs, got, cur;
    hp = chans; dp = chans; hs = 0; got = 0; cur = 0;
    for (int i = 0; i < 4; i++) bt[i] = 0;
    for (int cyc = 0; cyc < 200 && got < n; cyc++) begin
      s_txhdr_tvalid  = hp;
      s_txdata_tvalid = dp;
      for (int i = 0; i < 4; i++) begin
        s_txhdr_tdata[64*i +: 64]  = tx_hdr_word(i);
        s_txdata_tdata[64*i +: 64] = tx_word(i, bt[i]);
        s_txdata_tkeep[8*i +: 8]   = 8'hFF;
        s_txdata_tlast[i]          = (bt[i] == 1);
      end
      #1;
      check("tx_rdy_onehot",
            64'($countones(s_txhdr_tready | s_txdata_tready) <= 1), 64'd1);
      if (m_txhdr_tvalid && m_txhdr_tready) begin
        if (hs < 4) cur = exp_ch[hs];
        hs++;
        check("tx_tuser", 64'(m_txhdr_tuser), 64'(21600 + cur));
        check("tx_hdr", m_txhdr_tdata, tx_hdr_word(cur));
      end
      if (m_txdata_tvalid && m_txdata_tready) begin
        check("tx_data", m_txdata_tdata, tx_word(cur, bt[cur]));
        check("tx_last", 64'(m_txdata_tlast), 64'(bt[cur] == 1));
      end
      hr = s_txhdr_tready;
      dr = s_txdata_tready;
      step();
      for (int i = 0; i < 4; i++) begin
        if (hr[i] && hp[i]) hp[i] = 1'b0;
        if (dr[i] && dp[i]) begin
          bt[i]++;
          if (bt[i] == 2) begin
            dp[i] = 1'b0;
            got++;
          end
        end
      end
    end
    check("tx_pkts_done", 64'(got), 64'(n));
    s_txhdr_tvalid  = '0;
    s_txdata_tvalid = '0;
    s_txdata_tlast  = '0;
  endtask

  initial begin
    rst_n            = 1'b0;
    s_udphdr_tvalid  = 1'b0;
    s_udphdr_tdata   = '0;
    s_udphdr_tdest   = '0;
    s_udpdata_tvalid = 1'b0;
    s_udpdata_tlast  = 1'b0;
    s_udpdata_tdata  = '0;
    s_udpdata_tkeep  = 8'hFF;
    m_udphdr_tready  = '0;
    m_udpdata_tready = 4'hF;
    s_txhdr_tvalid   = '0;
    s_txhdr_tdata    = '0;
    s_txdata_tvalid  = '0;
    s_txdata_tlast   = '0;
    s_txdata_tdata   = '0;
    s_txdata_tkeep   = '0;
    m_txhdr_tready   = 1'b1;
    m_txdata_tready  = 1'b1;

    // ---------------- reset state ----------------
    #13;
    check("rst_udphdr_tready", 64'(s_udphdr_tready), 64'd0);
    check("rst_m_udphdr_tvalid", 64'(m_udphdr_tvalid), 64'd0);
    check("rst_m_udphdr_tdata", m_udphdr_tdata[63:0], 64'd0);
    check("rst_m_txhdr_tvalid", 64'(m_txhdr_tvalid), 64'd0);
    check("rst_drop_count", 64'(drop_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();

    // ---------------- RX to channel 2, 3 beats ----------------
    rx_hdr(16'd21602, 64'hC0A8_0001_1234_0018);
    #1;
    check("rx2_hdr_valid", 64'(m_udphdr_tvalid), 64'h4);
    check("rx2_hdr_data", m_udphdr_tdata[128 +: 64], 64'hC0A8_0001_1234_0018);
    check("rx2_no_data_yet", 64'(m_udpdata_tvalid), 64'd0);
    step();
    check("rx2_hdr_held", 64'(m_udphdr_tvalid), 64'h4);
    m_udphdr_tready = 4'h4;
    step();
    for (int b = 0; b < 3; b++) begin
      s_udpdata_tvalid = 1'b1;
      s_udpdata_tdata  = 64'hA000_0000_0000_0000 | 64'(b);
      s_udpdata_tlast  = (b == 2);
      #1;
      check("rx2_tvalid", 64'(m_udpdata_tvalid), 64'h4);
      check("rx2_tdata", m_udpdata_tdata[128 +: 64], 64'hA000_0000_0000_0000 | 64'(b));
      check("rx2_tlast", 64'(m_udpdata_tlast), (b == 2) ? 64'h4 : 64'h0);
      check("rx2_tready", 64'(s_udpdata_tready), 64'd1);
      check("rx2_hdr_gone", 64'(m_udphdr_tvalid), 64'd0);
      step();
    end
    s_udpdata_tvalid = 1'b0;
    s_udpdata_tlast  = 1'b0;
    #1;
    check("rx2_done_idle", 64'(m_udpdata_tvalid), 64'd0);
    check("rx2_back_idle", 64'(s_udphdr_tready), 64'd1);

    // ---------------- RX channel 1 with 5-cycle backpressure ----------------
    m_udphdr_tready = 4'hF;
    rx_hdr(16'd21601, 64'h0A0B_0C0D_4321_0020);
    #1;
    check("rx1_hdr_valid", 64'(m_udphdr_tvalid), 64'h2);
    step();
    for (int b = 0; b < 4; b++) begin
      s_udpdata_tvalid = 1'b1;
      s_udpdata_tdata  = 64'hB100_0000_0000_0000 | 64'(b);
      s_udpdata_tlast  = (b == 3);
      if (b == 1) begin
        m_udpdata_tready = 4'b1101;
        for (int s = 0; s < 5; s++) begin
          #1;
          check("bp_tready_low", 64'(s_udpdata_tready), 64'd0);
          check("bp_valid_held", 64'(m_udpdata_tvalid), 64'h2);
          check("bp_data_held", m_udpdata_tdata[64 +: 64], 64'hB100_0000_0000_0001);
          step();
        end
        m_udpdata_tready = 4'hF;
      end
      #1;
      check("rx1_tready", 64'(s_udpdata_tready), 64'd1);
      check("rx1_tdata", m_udpdata_tdata[64 +: 64], 64'hB100_0000_0000_0000 | 64'(b));
      check("rx1_tvalid", 64'(m_udpdata_tvalid), 64'h2);
      step();
    end
    s_udpdata_tvalid = 1'b0;
    s_udpdata_tlast  = 1'b0;
    #1;
    check("rx1_back_idle", 64'(s_udphdr_tready), 64'd1);

    // ---------------- drops and saturation ----------------
    check("drop_cnt_start", 64'(drop_count), 64'd0);
    rx_drop(16'd21700, 4);
    check("drop_cnt_one", 64'(drop_count), 64'd1);
    rx_drop(16'd21599, 1);   // below base, zero-length packet
    check("drop_cnt_wrap", 64'(drop_count), 64'd2);
    for (int k = 0; k < 13; k++) rx_drop(16'd30000, 2);
    check("drop_cnt_max", 64'(drop_count), 64'd15);
    rx_drop(16'd21700, 1);
    check("drop_cnt_sat", 64'(drop_count), 64'd15);

    // ---------------- TX round robin ----------------
    exp_ch = '{0, 1, 3, 0};
    tx_run(4'b1011, 3);
    exp_ch = '{0, 2, 0, 0};   // pointer wrapped to 0 after channel 3
    tx_run(4'b0101, 2);

    // ---------------- reset during TX DATA beat 2 ----------------
    s_txhdr_tdata[128 +: 64]  = tx_hdr_word(2);
    s_txdata_tdata[128 +: 64] = tx_word(2, 0);
    s_txdata_tkeep            = '1;
    s_txhdr_tvalid            = 4'b0100;
    s_txdata_tvalid           = 4'b0100;
    step();
    check("rst_tx_hdr_valid", 64'(m_txhdr_tvalid), 64'd1);
    check("rst_tx_tuser", 64'(m_txhdr_tuser), 64'd21602);
    step();
    s_txhdr_tvalid = '0;
    #1;
    check("rst_tx_beat1", m_txdata_tdata, tx_word(2, 0));
    step();
    s_txdata_tdata[128 +: 64] = tx_word(2, 1);
    s_txdata_tlast            = 4'b0100;
    #1;
    check("rst_tx_beat2_valid", 64'(m_txdata_tvalid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_txdata_valid", 64'(m_txdata_tvalid), 64'd0);
    check("rst_mid_txhdr_valid", 64'(m_txhdr_tvalid), 64'd0);
    check("rst_mid_txdata_ready", 64'(s_txdata_tready), 64'd0);
    check("rst_mid_drop_count", 64'(drop_count), 64'd0);
    check("rst_mid_udphdr_tready", 64'(s_udphdr_tready), 64'd0);
    s_txdata_tvalid = '0;
    s_txdata_tlast  = '0;
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    check("post_rst_no_beat", 64'(m_txdata_tvalid), 64'd0);
    // rr_ptr must be back to 0: channel 0 wins over channel 3
    exp_ch = '{0, 3, 0, 0};
    tx_run(4'b1001, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_turf_udp_port_switch
`default_nettype wire

// File: doc/turf_udp_port_switch.md
TURF_UDP_PORT_SWITCH -- requirements
Module: turf_udp_port_switch

Interface
REQ-001 SHALL have parameters: NUM_PORTS, 4, number of UDP channels (1..8); PORT_BASE, 16'd21600, UDP port of channel 0, channel i = PORT_BASE+i; DATA_WIDTH, 64, payload width (64 or 128); CNT_WIDTH, 32, drop-counter width.
REQ-002 SHALL have ports: clk  in  1  sole clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-003 s_udphdr_tvalid/tready  in/out  1  received header handshake; s_udphdr_tdata  in  64  {src ip[63:32], src port[31:16], length[15:0]}; s_udphdr_tdest  in  16  dst port.
REQ-004 s_udpdata_tvalid/tready/tlast  in/out/in  1; s_udpdata_tdata  in  DATA_WIDTH; s_udpdata_tkeep  in  DATA_WIDTH/8  received payload.
REQ-005 m_udphdr_tvalid/tready  out/in  NUM_PORTS; m_udphdr_tdata  out  NUM_PORTS*64  per-channel received header, channel i at [64*i +: 64].
REQ-006 m_udpdata_tvalid/tready/tlast  out/in/out  NUM_PORTS; m_udpdata_tdata  out  NUM_PORTS*DATA_WIDTH; m_udpdata_tkeep  out  NUM_PORTS*DATA_WIDTH/8  per-channel payload.
REQ-007 s_txhdr_tvalid/tready  in/out  NUM_PORTS; s_txhdr_tdata  in  NUM_PORTS*64  {dst ip, dst port, length} per channel.
REQ-008 s_txdata_tvalid/tready/tlast  in/out/in  NUM_PORTS; s_txdata_tdata  in  NUM_PORTS*DATA_WIDTH; s_txdata_tkeep  in  NUM_PORTS*DATA_WIDTH/8.
REQ-009 m_txhdr_tvalid/tready  out/in  1; m_txhdr_tdata  out  64; m_txhdr_tuser  out  16  source port; m_txdata_tvalid/tready/tlast, tdata, tkeep  single merged transmit stream.
REQ-010 drop_count  out  CNT_WIDTH  packets discarded for unmatched dst port.

Function
REQ-011 RX FSM states SHALL be IDLE, HDR, DATA, DROP.
REQ-012 IDLE: on s_udphdr_tvalid, SHALL register header and idx = tdest-PORT_BASE (16-bit unsigned wrap), assert s_udphdr_tready one cycle, go HDR if idx<NUM_PORTS else DROP.
REQ-013 HDR: SHALL assert only m_udphdr_tvalid[idx] with registered header; on tready go DATA.
REQ-014 DATA: SHALL route s_udpdata to channel idx combinationally (tready from m_udpdata_tready[idx], other channels tvalid=0); on accepted tlast beat go IDLE.
REQ-015 DROP: SHALL hold s_udpdata_tready=1, discard beats; on accepted tlast beat increment drop_count (saturating at all-ones) and go IDLE.
REQ-016 Tdest below PORT_BASE SHALL wrap to a large idx and be dropped.
REQ-017 Header-to-channel latency SHALL be 2 cycles minimum (IDLE register, HDR present); payload adds 0 cycles.
REQ-018 TX FSM states SHALL be IDLE, HDR, DATA.
REQ-019 IDLE: SHALL grant the first channel with s_txhdr_tvalid searching from rr_ptr upward modulo NUM_PORTS; go HDR.
REQ-020 HDR: m_txhdr_tdata = s_txhdr_tdata[grant], m_txhdr_tuser = PORT_BASE+grant, s_txhdr_tready[grant]=m_txhdr_tready; on handshake go DATA.
REQ-021 DATA: SHALL forward s_txdata[grant] only; on accepted tlast beat set rr_ptr=grant+1 (wrap to 0 at NUM_PORTS), go IDLE.
REQ-022 Grant SHALL never change mid-packet; ungranted channels see tready=0.
REQ-023 RX and TX FSMs SHALL operate independently; simultaneous activity permitted.
REQ-024 Zero-length packets (single tlast beat) SHALL be handled identically.

Reset
REQ-025 rst_n low SHALL asynchronously force both FSMs to IDLE, all tvalid/tready outputs 0, drop_count 0, rr_ptr 0, grant 0, registered header 0.
REQ-026 Reset mid-packet SHALL abandon the packet; no partial beats after deassertion.

Structure
REQ-027 Shared package SHALL hold RX/TX state encodings and header field offsets (IP 32, port 16, length 0).
REQ-028 One sub-module turf_udp_rr_arb (NUM_PORTS requests, rr_ptr in, one-hot/index grant out) SHALL implement REQ-019.

Verification
REQ-029 RX hdr tdest=21602, 3-beat payload -> channel 2 gets header at 2 cycles, 3 beats, tlast on beat 3; others idle.
REQ-030 RX tdest=21700 with 4 beats -> all beats accepted, no channel valid, drop_count 0->1.
REQ-031 TX channels 0,1,3 valid at once, 2-beat packets -> order 0,1,3, tuser 21600,21601,21603; then next ch0 packet after ch3.
REQ-032 m_udpdata_tready[1]=0 for 5 cycles mid-packet -> s_udpdata_tready=0 those cycles, data held, no loss.
REQ-033 rst_n low during TX DATA beat 2 -> all valids 0 same cycle, rr_ptr 0, drop_count 0; next packet starts cleanly.
REQ-034 drop_count preset near max (CNT_WIDTH=4, 15 drops then one more) -> holds 15.
